rf_arb: RTL

RF_ARB -- requirements
Module: rf_arb

---
 rtl/rf_arb.sv | 111 +++++++++++
 1 files changed

// File: rtl/rf_arb.sv
// rtl/rf_arb.sv - two-requester round-robin arbiter in front of a single-port register file
`timescale 1ns/1ps

module rf_arb #(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [1:0]                      req_valid_i,
    output logic [1:0]                      req_ready_o,
    input  logic [1:0]                      req_we_i,
    input  logic [2*$clog2(DEPTH)-1:0]      req_addr_i,
    input  logic [2*DATA_WIDTH-1:0]         req_data_i,
    output logic [1:0]                      rsp_valid_o,
    output logic [DATA_WIDTH-1:0]           rsp_data_o,
    output logic                            rsp_err_o,
    output logic                            rf_en_o,
    output logic                            rf_we_o,
    output logic [$clog2(DEPTH)-1:0]        rf_addr_o,
    output logic [DATA_WIDTH-1:0]           rf_data_o,
    input  logic [DATA_WIDTH-1:0]           rf_data_i,
    output logic                            busy_o
);

    localparam int AW = $clog2(DEPTH);
    // One extra bit so DEPTH itself is representable when DEPTH is a power of two.
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                  state_q, state_d;
    logic                    last_q;
    logic                    idx_q;
    logic                    we_q;
    logic                    err_q;
    logic [AW-1:0]           addr_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic                    win;
    logic                    grant;
    logic                    in_range;

    // Requester 1 wins when alone, or on a tie when requester 0 was granted last.
    assign win      = req_valid_i[1] & (~req_valid_i[0] | ~last_q);
    assign in_range = ({1'b0, addr_q} < DEPTH_W);
    assign busy_o   = (state_q != IDLE);

    always_comb begin
        state_d     = state_q;
        grant       = 1'b0;
        req_ready_o = 2'b00;
        rf_en_o     = 1'b0;
        rf_we_o     = 1'b0;
        rf_addr_o   = '0;
        rf_data_o   = '0;
        rsp_valid_o = 2'b00;
        rsp_data_o  = '0;
        rsp_err_o   = 1'b0;
        case (state_q)
            IDLE: begin
                if ((|req_valid_i) && !rst_i) begin
                    grant            = 1'b1;
                    req_ready_o[win] = 1'b1;
                    state_d          = ACCESS;
                end
            end
            ACCESS: begin
                if (in_range) begin
                    rf_en_o   = 1'b1;
                    rf_we_o   = we_q;
                    rf_addr_o = addr_q;
                    rf_data_o = data_q;
                end
                state_d = RESP;
            end
            RESP: begin
                rsp_valid_o[idx_q] = 1'b1;
                rsp_err_o          = err_q;
                rsp_data_o         = err_q ? '0 : rf_data_i;
                state_d            = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            idx_q   <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                last_q <= win;
                idx_q  <= win;
                we_q   <= req_we_i[win];
                addr_q <= win ? req_addr_i[2*AW-1:AW] : req_addr_i[AW-1:0];
                data_q <= win ? req_data_i[2*DATA_WIDTH-1:DATA_WIDTH]
                              : req_data_i[DATA_WIDTH-1:0];
            end
            if (state_q == ACCESS) begin
                err_q <= ~in_range;
            end
        end
    end

endmodule
